// File: rtl/residual_join_fifo.sv
// Residual join: skip-path beats wait in an elastic FIFO and are popped one-for-one against
// main-path beats, then combined per channel by FP_Adder lanes with frame-end tagging.

// Single-precision adder with one register stage. Normal operands only; no inf/NaN handling.
module FP_Adder (
    input  logic        clk,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Mode,
    input  logic [1:0]  RMode,
    input  logic        Valid_In,
    output logic [31:0] Result
);
    logic        sa, sb, sx, sy, rnd;
    logic [7:0]  ex, ey, shift;
    logic [26:0] mx, my, my_al, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [8:0]  exp_n;
    logic [23:0] frac_r;
    logic [31:0] res_c;

    always_comb begin
        sa = A[31];
        sb = B[31] ^ Mode;
        if (A[30:0] >= B[30:0]) begin
            sx = sa; ex = A[30:23]; mx = {|A[30:23], A[22:0], 3'b000};
            sy = sb; ey = B[30:23]; my = {|B[30:23], B[22:0], 3'b000};
        end else begin
            sx = sb; ex = B[30:23]; mx = {|B[30:23], B[22:0], 3'b000};
            sy = sa; ey = A[30:23]; my = {|A[30:23], A[22:0], 3'b000};
        end
        shift = ex - ey;
        my_al = (shift > 8'd26) ? 27'd0 : (my >> shift);
        if (sx == sy) sum = {1'b0, mx} + {1'b0, my_al};
        else          sum = {1'b0, mx} - {1'b0, my_al};
        lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
        if (sum[27]) begin
            norm  = sum[27:1];
            exp_n = {1'b0, ex} + 9'd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = {1'b0, ex} - {4'b0000, lz};
        end
        // Round to nearest-even on the guard bit when RMode=00, otherwise truncate.
        rnd    = (RMode == 2'b00) && norm[2] && (norm[3] || (|norm[1:0]));
        frac_r = {1'b0, norm[25:3]} + {23'd0, rnd};
        if (frac_r[23]) exp_n = exp_n + 9'd1;
        res_c = norm[26] ? {sx, exp_n[7:0], frac_r[22:0]} : 32'h0000_0000;
    end

    always_ff @(posedge clk) begin
        if (Valid_In) Result <= res_c;
    end
endmodule

module residual_join_fifo #(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNELS   = 16,
    parameter int SKIP_DEPTH = 256,
    parameter int IMG_WIDHT  = 44,
    parameter int IMG_HEIGHT = 44,
    parameter int ADD_LAT    = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDHT*CHANNELS-1:0] Main_Data_In,
    input  logic                           Main_Valid_In,
    input  logic [DATA_WIDHT*CHANNELS-1:0] Skip_Data_In,
    input  logic                           Skip_Valid_In,
    input  logic [1:0]                     Mode,
    output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
    output logic                           Valid_Out,
    output logic                           Last_Out,
    output logic [$clog2(SKIP_DEPTH):0]    Fill_Level,
    output logic                           Overflow,
    output logic                           Underflow
);
    localparam int BW    = DATA_WIDHT * CHANNELS;
    localparam int PW    = $clog2(SKIP_DEPTH);
    localparam int FRAME = IMG_WIDHT * IMG_HEIGHT;
    localparam int FW    = $clog2(FRAME);
    localparam logic [PW:0]   FULL_LVL = (PW+1)'(SKIP_DEPTH);
    localparam logic [FW-1:0] LAST_IDX = FW'(FRAME - 1);

    logic [BW-1:0]      mem [SKIP_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [FW-1:0]      frame_cnt;
    logic               push_ok, pop_ok, frame_end;
    logic [BW-1:0]      a_q, b_q;
    logic [1:0]         mode_q;
    logic               align_valid, align_last;
    logic [ADD_LAT-1:0] v_pipe, l_pipe;

    // Pop is judged on start-of-cycle occupancy, so a same-cycle push never satisfies it.
    assign push_ok   = Skip_Valid_In && (Fill_Level != FULL_LVL);
    assign pop_ok    = Main_Valid_In && (Fill_Level != '0);
    assign frame_end = (frame_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            Fill_Level  <= '0;
            frame_cnt   <= '0;
            Overflow    <= 1'b0;
            Underflow   <= 1'b0;
            align_valid <= 1'b0;
            align_last  <= 1'b0;
            v_pipe      <= '0;
            l_pipe      <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                rd_ptr    <= rd_ptr + 1'b1;
                frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
            end
            if (Skip_Valid_In && !push_ok) Overflow  <= 1'b1;
            if (Main_Valid_In && !pop_ok)  Underflow <= 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   Fill_Level <= Fill_Level + 1'b1;
                2'b01:   Fill_Level <= Fill_Level - 1'b1;
                default: Fill_Level <= Fill_Level;
            endcase
            align_valid <= pop_ok;
            align_last  <= pop_ok && frame_end;
            v_pipe[0]   <= align_valid;
            l_pipe[0]   <= align_last;
            for (int i = 1; i < ADD_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                l_pipe[i] <= l_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= Skip_Data_In;
        if (pop_ok) begin
            a_q    <= Main_Data_In;
            b_q    <= mem[rd_ptr];
            mode_q <= Mode;
        end
    end

    assign Valid_Out = v_pipe[ADD_LAT-1];
    assign Last_Out  = l_pipe[ADD_LAT-1];

    // Mode 11 behaves as 00; mode 10 feeds +0.0 on the skip operand.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        FP_Adder u_add (
            .clk      (clk),
            .A        (a_q[c*DATA_WIDHT +: DATA_WIDHT]),
            .B        ((mode_q == 2'b10) ? {DATA_WIDHT{1'b0}} : b_q[c*DATA_WIDHT +: DATA_WIDHT]),
            .Mode     (mode_q == 2'b01),
            .RMode    (2'b00),
            .Valid_In (align_valid),
            .Result   (Data_Out[c*DATA_WIDHT +: DATA_WIDHT])
        );
    end
endmodule

// File: tb/tb_residual_join_fifo.sv
// Scoreboard bench for residual_join_fifo: stimulus queues expected beats, a negedge monitor
// compares every presented output; status outputs are checked directly after each step.
module tb_residual_join_fifo;
    localparam int W     = 32;
    localparam int C     = 16;
    localparam int BW    = W * C;
    localparam int DEPTH = 256;
    localparam int FRAME = 44 * 44;

    localparam logic [31:0] F_ONE   = 32'h3F80_0000;
    localparam logic [31:0] F_TWO   = 32'h4000_0000;
    localparam logic [31:0] F_THREE = 32'h4040_0000;
    localparam logic [31:0] F_FOUR  = 32'h4080_0000;
    localparam logic [31:0] F_PI    = 32'h4049_0FDB;
    localparam logic [31:0] F_INF   = 32'h7F80_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] main_data = '0;
    logic          main_valid = 1'b0;
    logic [BW-1:0] skip_data = '0;
    logic          skip_valid = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [BW-1:0] data_out;
    logic          valid_out, last_out, overflow, underflow;
    logic [8:0]    fill_level;

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   pop_cnt = 0;

    residual_join_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .Main_Data_In  (main_data),
        .Main_Valid_In (main_valid),
        .Skip_Data_In  (skip_data),
        .Skip_Valid_In (skip_valid),
        .Mode          (mode),
        .Data_Out      (data_out),
        .Valid_Out     (valid_out),
        .Last_Out      (last_out),
        .Fill_Level    (fill_level),
        .Overflow      (overflow),
        .Underflow     (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] splat(input logic [31:0] v);
        return {C{v}};
    endfunction

    // Distinct normal float per beat and lane; adding +0.0 to it returns it unchanged.
    function automatic logic [BW-1:0] bval(input int k);
        logic [BW-1:0] r;
        for (int c = 0; c < C; c++) r[c*W +: W] = 32'h4000_0000 | (32'(k) << 5) | 32'(c);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic mv, input logic [BW-1:0] ma, input logic sv,
                       input logic [BW-1:0] sb, input logic [1:0] md);
        main_valid = mv; main_data = ma;
        skip_valid = sv; skip_data = sb;
        mode = md;
        step();
        main_valid = 1'b0;
        skip_valid = 1'b0;
    endtask

    task automatic expect_beat(input logic [BW-1:0] d);
        exp_t e;
        e.data = d;
        e.last = (pop_cnt == FRAME - 1);
        exp_q.push_back(e);
        pop_cnt = (pop_cnt == FRAME - 1) ? 0 : pop_cnt + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, 1'b0, '0, 2'b00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        pop_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got beat %h, expected no output", data_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (data_out !== mon_e.data || last_out !== mon_e.last) begin
                    bad++;
                    $display("FAIL out_beat: got %h last=%0b, expected %h last=%0b",
                             data_out, last_out, mon_e.data, mon_e.last);
                end
            end
        end else if (last_out) begin
            total++;
            bad++;
            $display("FAIL last_without_valid: got Last_Out=1, expected 0");
        end
    end

    initial begin
        do_reset();
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_last", 32'(last_out), 0);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);

        // 2.0 + 1.0 = 3.0 on three beats
        repeat (3) cyc(1'b0, '0, 1'b1, splat(F_TWO), 2'b00);
        chk("t1_fill3", 32'(fill_level), 3);
        repeat (3) begin
            expect_beat(splat(F_THREE));
            cyc(1'b1, splat(F_ONE), 1'b0, '0, 2'b00);
        end
        chk("t1_fill0", 32'(fill_level), 0);
        idle(4);

        // subtract, main-only with an infinite skip operand, per-beat mode switching
        cyc(1'b0, '0, 1'b1, splat(F_ONE), 2'b00);
        cyc(1'b0, '0, 1'b1, splat(F_INF), 2'b00);
        expect_beat(splat(F_TWO));
        cyc(1'b1, splat(F_THREE), 1'b0, '0, 2'b01);
        expect_beat(splat(F_PI));
        cyc(1'b1, splat(F_PI), 1'b0, '0, 2'b10);
        repeat (4) cyc(1'b0, '0, 1'b1, splat(F_ONE), 2'b00);
        expect_beat(splat(F_FOUR));
        cyc(1'b1, splat(F_THREE), 1'b0, '0, 2'b00);
        expect_beat(splat(F_TWO));
        cyc(1'b1, splat(F_THREE), 1'b0, '0, 2'b01);
        expect_beat(splat(F_THREE));
        cyc(1'b1, splat(F_THREE), 1'b0, '0, 2'b10);
        expect_beat(splat(F_FOUR));
        cyc(1'b1, splat(F_THREE), 1'b0, '0, 2'b11);
        idle(4);

        // fill to capacity, overflow on the first drop, drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, bval(i), 2'b00);
        chk("t3_full", 32'(fill_level), DEPTH);
        chk("t3_no_ovf_yet", 32'(overflow), 0);
        cyc(1'b0, '0, 1'b1, bval(900), 2'b00);
        chk("t3_ovf_first_drop", 32'(overflow), 1);
        cyc(1'b0, '0, 1'b1, bval(901), 2'b00);
        chk("t3_fill_capped", 32'(fill_level), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            expect_beat(bval(i));
            cyc(1'b1, '0, 1'b0, '0, 2'b00);
        end
        chk("t3_drained", 32'(fill_level), 0);
        chk("t3_ovf_sticky", 32'(overflow), 1);

        // pointer wrap with concurrent push and pop
        for (int i = 0; i < 200; i++) cyc(1'b0, '0, 1'b1, bval(1000 + i), 2'b00);
        for (int i = 0; i < 200; i++) begin
            expect_beat(bval(1000 + i));
            cyc(1'b1, '0, 1'b1, bval(1200 + i), 2'b00);
        end
        chk("t3_wrap_fill", 32'(fill_level), 200);
        for (int i = 0; i < 200; i++) begin
            expect_beat(bval(1200 + i));
            cyc(1'b1, '0, 1'b0, '0, 2'b00);
        end
        idle(4);

        // pop on empty with a concurrent push: main beat dropped
        chk("t4_unf_before", 32'(underflow), 0);
        cyc(1'b1, splat(F_ONE), 1'b1, bval(7), 2'b00);
        chk("t4_unf", 32'(underflow), 1);
        chk("t4_fill1", 32'(fill_level), 1);
        expect_beat(bval(7));
        cyc(1'b1, '0, 1'b0, '0, 2'b00);
        idle(4);

        // two full frames with 1-cycle skew: 1+1 then 1+3
        do_reset();
        for (int k = 0; k <= 2 * FRAME; k++) begin
            logic          mv, sv;
            logic [BW-1:0] sb;
            mv = (k > 0);
            sv = (k < 2 * FRAME);
            sb = (k < FRAME) ? splat(F_ONE) : splat(F_THREE);
            if (mv) expect_beat((k - 1 < FRAME) ? splat(F_TWO) : splat(F_FOUR));
            cyc(mv, splat(F_ONE), sv, sb, 2'b00);
        end
        idle(4);
        chk("t5_fill0", 32'(fill_level), 0);

        // reset with beats queued and one in flight
        cyc(1'b1, splat(F_ONE), 1'b0, '0, 2'b00);
        chk("t6_unf_set", 32'(underflow), 1);
        repeat (6) cyc(1'b0, '0, 1'b1, splat(F_TWO), 2'b00);
        cyc(1'b1, splat(F_ONE), 1'b0, '0, 2'b00);
        chk("t6_fill5", 32'(fill_level), 5);
        rst = 1'b1;
        step();
        chk("t6_valid", 32'(valid_out), 0);
        chk("t6_last", 32'(last_out), 0);
        chk("t6_fill", 32'(fill_level), 0);
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_unf", 32'(underflow), 0);
        rst = 1'b0;
        pop_cnt = 0;
        idle(6);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
